// File: rtl/xp2s_lane_if.sv
// Parallel-word / serial-lane handshake bundle for xp2s_lane.
// The master side is the producer of words and the consumer of lanes.
interface xp2s_lane_if #(
  parameter int BWID = 8,
  parameter int Npar = 4
);
  logic [BWID*Npar-1:0] iv_data;
  logic                 i_dv;
  logic                 i_trig;
  logic                 o_rdy;
  logic                 i_ce;
  logic [BWID-1:0]      ov_data;
  logic                 o_nd;
  logic                 o_trig;
  logic                 o_ovf;
  logic                 o_busy;

  modport master (
    output iv_data, i_dv, i_trig, i_ce,
    input  o_rdy, ov_data, o_nd, o_trig, o_ovf, o_busy
  );

  modport slave (
    input  iv_data, i_dv, i_trig, i_ce,
    output o_rdy, ov_data, o_nd, o_trig, o_ovf, o_busy
  );
endinterface

// File: rtl/xp2s_lane.sv
// Parallel-to-serial lane converter: one Npar-lane word in, one lane out per
// enabled cycle (lane 0 first), with a one-word pending buffer for gap-free output.

// Per-lane tap: passes its lane only when the lane counter points at it.
module xp2s_lane_tap #(
  parameter int BWID = 8
) (
  input  logic            sel,
  input  logic [BWID-1:0] din,
  output logic [BWID-1:0] dout
);
  assign dout = sel ? din : '0;
endmodule

module xp2s_lane #(
  parameter int BWID = 8,
  parameter int Npar = 4
) (
  input  logic       clk,
  input  logic       rst,
  xp2s_lane_if.slave bus
);
  localparam int            CW   = (Npar > 1) ? $clog2(Npar) : 1;
  localparam logic [CW-1:0] LAST = CW'(Npar - 1);

  typedef logic [Npar-1:0][BWID-1:0] word_t;
  typedef struct packed {
    word_t data;
    logic  trig;
    logic  vld;
  } slot_t;

  slot_t           act_q, act_d, pnd_q, pnd_d, in_slot;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BWID-1:0] data_q, data_d, lane_mux;
  logic            nd_q, nd_d, trig_q, trig_d, ovf_q, busy_q;
  logic            emit, fin, acc;
  word_t           tap;

  always_comb begin
    in_slot      = '0;
    in_slot.data = word_t'(bus.iv_data);
    in_slot.trig = bus.i_trig;
    in_slot.vld  = 1'b1;
  end

  assign emit = act_q.vld && bus.i_ce;
  assign fin  = emit && (cnt_q == LAST);
  // Readiness depends on stored state only, so a producer may look at o_rdy
  // before deciding to raise i_dv.
  assign acc  = bus.i_dv && !pnd_q.vld;

  for (genvar k = 0; k < Npar; k++) begin : g_lane
    xp2s_lane_tap #(.BWID(BWID)) u_tap (
      .sel  (cnt_q == CW'(k)),
      .din  (act_q.data[k]),
      .dout (tap[k])
    );
  end

  always_comb begin
    lane_mux = '0;
    for (int k = 0; k < Npar; k++) lane_mux = lane_mux | tap[k];
  end

  always_comb begin
    act_d  = act_q;
    pnd_d  = pnd_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    nd_d   = 1'b0;
    trig_d = 1'b0;
    if (emit) begin
      data_d = lane_mux;
      nd_d   = 1'b1;
      trig_d = act_q.trig && (cnt_q == '0);
      cnt_d  = fin ? '0 : cnt_q + CW'(1);
    end
    // On the last lane the next word (pending first, else the incoming one)
    // moves straight into active so output continues without a bubble.
    if (fin) begin
      if (pnd_q.vld) begin
        act_d     = pnd_q;
        pnd_d.vld = 1'b0;
      end else if (acc) begin
        act_d = in_slot;
      end else begin
        act_d.vld = 1'b0;
      end
    end else if (acc) begin
      if (!act_q.vld) act_d = in_slot;
      else            pnd_d = in_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= '0;
      pnd_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      nd_q   <= 1'b0;
      trig_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      pnd_q  <= pnd_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      nd_q   <= nd_d;
      trig_q <= trig_d;
      ovf_q  <= bus.i_dv && pnd_q.vld;
      busy_q <= act_d.vld || pnd_d.vld;
    end
  end

  assign bus.o_rdy   = !pnd_q.vld;
  assign bus.ov_data = data_q;
  assign bus.o_nd    = nd_q;
  assign bus.o_trig  = trig_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_busy  = busy_q;

  // A pending word can only exist behind an active one.
  a_pnd_needs_act: assert property (@(posedge clk) disable iff (rst)
    pnd_q.vld |-> act_q.vld);
endmodule

// File: doc/xp2s_lane.md
Name: xp2s_lane

Overview:
- Parallel-to-serial lane converter; the transmit-side counterpart of the team's serial-to-parallel block.
- Accepts one word of Npar lanes, each BWID bits wide, and emits the lanes one per enabled cycle, lane 0 first.
- A one-word pending buffer allows gap-free back-to-back output.
- Sits between a wide datapath stage and a narrow serial consumer; the consumer paces output via i_ce.

Parameters:
BWID, 8, lane width in bits
Npar, 4, lanes per parallel word (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
iv_data  in  BWID*Npar  parallel word; lane k = iv_data[BWID*k +: BWID]
i_dv  in  1  word valid
i_trig  in  1  frame marker, sampled with the word
o_rdy  out  1  block can accept a word this cycle
i_ce  in  1  output advance enable; one lane is emitted per cycle with i_ce=1
ov_data  out  BWID  serial lane output (registered)
o_nd  out  1  ov_data valid strobe
o_trig  out  1  high with lane 0 of a word accepted with i_trig=1
o_ovf  out  1  one-cycle pulse: i_dv=1 while o_rdy=0 (word dropped)
o_busy  out  1  active or pending word held

Behaviour:
- Reset: all internal state cleared (active/pending valid flags, cnt, stored trig flags).
  - ov_data=0, o_nd=0, o_trig=0, o_ovf=0, o_busy=0; o_rdy=1 from the first post-reset cycle.
  - Reset mid-word discards active and pending words; no further lanes are emitted.
- Storage:
  - active register: word + trig + valid.
  - pending register: word + trig + valid.
  - lane counter cnt, 0..Npar-1, width max(1, clog2(Npar)).
- o_rdy = !pending_valid; combinational from registers only, with no dependence on i_dv.
- Accept occurs when i_dv && o_rdy at a rising edge. Define fin = active_valid && i_ce && (cnt==Npar-1). The accepted word goes to:
  - active, if active_valid=0 or fin=1 (and pending empty);
  - otherwise pending.
- Emit: at an edge with i_ce=1 and active_valid=1:
  - ov_data <= lane[cnt]; o_nd <= 1; o_trig <= active_trig && (cnt==0);
  - cnt <= (cnt==Npar-1) ? 0 : cnt+1.
- Otherwise o_nd <= 0 and o_trig <= 0; ov_data holds its last value.
- End of word (fin=1): active takes pending if pending_valid (pending clears), else the word being accepted at this edge, else active_valid <= 0.
- i_ce=0 freezes cnt and the registers; acceptance into empty slots still occurs.
- Latency: accept at edge E into an idle block, with i_ce=1 thereafter → lane 0 on ov_data with o_nd=1 after edge E+1. Lanes follow on consecutive ce cycles.
- Throughput: one word per Npar ce cycles. With pending kept full, o_nd stays high continuously with no gap between words.
- Npar=1: each ce cycle emits a whole word; fin is true on every emit.
- o_ovf is registered: o_ovf <= i_dv && !o_rdy. The dropped word leaves all state unchanged.
- o_busy is registered: o_busy = active_valid || pending_valid, post-edge value.
- i_trig matters only on accepted words. There is no re-alignment: cnt always restarts at 0 for each new word.

Test Plan (BWID=8, Npar=4):
1. Single word: reset, then accept 0x44332211 with i_trig=1, i_ce=1 held → ov_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, o_nd=1 for exactly those 4 cycles, o_trig=1 only with 0x11, o_busy drops after 0x44.
2. Back-to-back: present 0x44332211 then 0x88776655 with i_dv held, i_ce=1 → 8 contiguous o_nd cycles, output 0x11..0x44 then 0x55..0x88. o_rdy=0 while pending is full; o_ovf never asserts.
3. Overflow: with active and pending full, present 0xDEADBEEF for one cycle → o_ovf pulses 1 cycle; output stream is unaffected and 0xDEADBEEF never appears.
4. Pacing: i_ce toggles 1,0,1,0 → one lane per i_ce=1 cycle, o_nd only on the cycles after i_ce=1, lane order preserved, cnt frozen while i_ce=0.
5. Reset mid-word: rst asserted after lane 0x22 is emitted → next cycle o_nd=0, o_busy=0, o_rdy=1. A new word 0xA4A3A2A1 then emits 0xA1 first.
6. Npar=1 build: words 0x5A, 0xA5 with i_ce=1 → one lane each, on consecutive cycles.
